// File: rtl/sh_extbus_bridge.sv
// SH7604 external-bus to request/acknowledge memory port bridge.
// Bus-side state advances on CE_R; the memory handshake is sampled on every CLK.
module sh_extbus_bridge #(
  parameter logic [3:0]  AREA_EN  = 4'b1111,
  parameter int unsigned MIN_WAIT = 0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic [26:0] A,
  input  logic [31:0] DO,
  output logic [31:0] DI,
  input  logic        BS_N,
  input  logic        CS0_N,
  input  logic        CS1_N,
  input  logic        CS2_N,
  input  logic        CS3_N,
  input  logic        RD_WR_N,
  input  logic        RD_N,
  input  logic [3:0]  WE_N,
  output logic        WAIT_N,
  output logic [26:0] MEM_A,
  output logic [31:0] MEM_DO,
  output logic [3:0]  MEM_BE,
  output logic        MEM_WR,
  output logic [1:0]  MEM_AREA,
  output logic        MEM_REQ,
  input  logic [31:0] MEM_DI,
  input  logic        MEM_ACK,
  output logic        BUS_ERR
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_HOLD, S_DONE, S_END} state_t;

  typedef struct packed {
    logic [26:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        wr;
    logic [1:0]  area;
  } req_t;

  state_t      state, state_nx;
  req_t        req_q;
  logic [7:0]  cnt;
  logic        ack_seen;
  logic        mem_req_q;
  logic [31:0] di_q;
  logic        bus_err_q;

  logic [3:0]  sel;
  logic [1:0]  area_enc;
  logic        start, cap, ack_hit, ack_now, min_met, tmo, tmo_fire, bus_rel;

  assign sel      = ~{CS3_N, CS2_N, CS1_N, CS0_N} & AREA_EN;
  assign start    = (state == S_IDLE) & ~BS_N & (|sel);
  assign cap      = CE_R & start;
  // Only an ACK against an outstanding request counts; stray or late ACKs fall out here.
  assign ack_hit  = mem_req_q & MEM_ACK;
  assign ack_now  = ack_seen | ack_hit;
  assign min_met  = cnt >= 8'(MIN_WAIT);
  assign tmo      = cnt == 8'(TIMEOUT);
  assign tmo_fire = CE_R & (state == S_REQ) & ~ack_now & tmo;
  assign bus_rel  = ~(|sel) | (RD_N & (&WE_N));

  always_comb begin
    area_enc = 2'd0;
    if (sel[0])      area_enc = 2'd0;
    else if (sel[1]) area_enc = 2'd1;
    else if (sel[2]) area_enc = 2'd2;
    else if (sel[3]) area_enc = 2'd3;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (cap) state_nx = S_REQ;
      S_REQ: begin
        if (CE_R) begin
          if (ack_now)  state_nx = min_met ? S_DONE : S_HOLD;
          else if (tmo) state_nx = S_DONE;
        end
      end
      S_HOLD: if (CE_R && min_met) state_nx = S_DONE;
      S_DONE: if (CE_R) state_nx = S_END;
      S_END:  if (CE_R && bus_rel) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_q     <= '0;
      cnt       <= '0;
      ack_seen  <= 1'b0;
      mem_req_q <= 1'b0;
      di_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (cap) begin
        req_q.addr <= A & 27'h7FF_FFFC;
        req_q.data <= DO;
        req_q.wr   <= ~RD_WR_N;
        req_q.be   <= RD_WR_N ? 4'hF : ~WE_N;
        req_q.area <= area_enc;
        cnt        <= '0;
        mem_req_q  <= 1'b1;
      end else if (CE_R && (state == S_REQ || state == S_HOLD) && cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
      if (ack_hit) begin
        ack_seen  <= 1'b1;
        mem_req_q <= 1'b0;
        if (!req_q.wr) di_q <= MEM_DI;
      end
      if (tmo_fire) begin
        mem_req_q <= 1'b0;
        if (!req_q.wr) di_q <= '1;
      end
      // Error strobe spans exactly the CE_R period following the timeout.
      if (CE_R) bus_err_q <= tmo_fire;
      if (CE_R && state == S_DONE) ack_seen <= 1'b0;
    end
  end

  assign WAIT_N   = ~(start | (state == S_REQ) | (state == S_HOLD));
  assign DI       = di_q;
  assign MEM_A    = req_q.addr;
  assign MEM_DO   = req_q.data;
  assign MEM_BE   = req_q.be;
  assign MEM_WR   = req_q.wr;
  assign MEM_AREA = req_q.area;
  assign MEM_REQ  = mem_req_q;
  assign BUS_ERR  = bus_err_q;

endmodule

// File: tb/tb_sh_extbus_bridge.sv
// Directed bench for sh_extbus_bridge: one default-ish instance and one with MIN_WAIT/AREA_EN set.
module tb_sh_extbus_bridge;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ce0 = 1'b0, ce1 = 1'b0;
  logic [26:0] A = '0;
  logic [31:0] DO = '0;
  logic        BS_N = 1'b1;
  logic [3:0]  cs_n = 4'hF;
  logic        RD_WR_N = 1'b1;
  logic        RD_N = 1'b1;
  logic [3:0]  WE_N = 4'hF;

  logic [31:0] mdi0 = '0, mdi1 = '0;
  logic        ack0 = 1'b0, ack1 = 1'b0;

  logic [31:0] di0, di1, mdo0, mdo1;
  logic [26:0] ma0, ma1;
  logic [3:0]  mbe0, mbe1;
  logic [1:0]  marea0, marea1;
  logic        wait0, wait1, mwr0, mwr1, mreq0, mreq1, berr0, berr1;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  sh_extbus_bridge #(.AREA_EN(4'b1111), .MIN_WAIT(0), .TIMEOUT(8)) u_dut0 (
    .CLK(CLK), .RST(RST), .CE_R(ce0), .A(A), .DO(DO), .DI(di0), .BS_N(BS_N),
    .CS0_N(cs_n[0]), .CS1_N(cs_n[1]), .CS2_N(cs_n[2]), .CS3_N(cs_n[3]),
    .RD_WR_N(RD_WR_N), .RD_N(RD_N), .WE_N(WE_N), .WAIT_N(wait0),
    .MEM_A(ma0), .MEM_DO(mdo0), .MEM_BE(mbe0), .MEM_WR(mwr0), .MEM_AREA(marea0),
    .MEM_REQ(mreq0), .MEM_DI(mdi0), .MEM_ACK(ack0), .BUS_ERR(berr0)
  );

  sh_extbus_bridge #(.AREA_EN(4'b1110), .MIN_WAIT(4), .TIMEOUT(255)) u_dut1 (
    .CLK(CLK), .RST(RST), .CE_R(ce1), .A(A), .DO(DO), .DI(di1), .BS_N(BS_N),
    .CS0_N(cs_n[0]), .CS1_N(cs_n[1]), .CS2_N(cs_n[2]), .CS3_N(cs_n[3]),
    .RD_WR_N(RD_WR_N), .RD_N(RD_N), .WE_N(WE_N), .WAIT_N(wait1),
    .MEM_A(ma1), .MEM_DO(mdo1), .MEM_BE(mbe1), .MEM_WR(mwr1), .MEM_AREA(marea1),
    .MEM_REQ(mreq1), .MEM_DI(mdi1), .MEM_ACK(ack1), .BUS_ERR(berr1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic release_bus();
    BS_N = 1'b1; cs_n = 4'hF; RD_N = 1'b1; WE_N = 4'hF; RD_WR_N = 1'b1;
  endtask

  task automatic start_rd(input int area, input logic [26:0] addr);
    A = addr; RD_WR_N = 1'b1; RD_N = 1'b0; WE_N = 4'hF;
    cs_n = 4'hF; cs_n[area] = 1'b0;
    BS_N = 1'b0;
    #1;
  endtask

  initial begin
    ce0 = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_wait_n", wait0, 1);
    chk("rst_di", di0, 0);
    chk("rst_mem_req", mreq0, 0);
    chk("rst_mem_a", ma0, 0);
    chk("rst_mem_do", mdo0, 0);
    chk("rst_mem_be", mbe0, 0);
    chk("rst_mem_wr", mwr0, 0);
    chk("rst_mem_area", marea0, 0);
    chk("rst_bus_err", berr0, 0);
    RST = 1'b0;
    step();

    // Read, area 0, ACK three CLKs after MEM_REQ rises
    start_rd(0, 27'h0000104);
    chk("s1_wait_at_start", wait0, 0);
    step();
    BS_N = 1'b1;
    chk("s1_mem_req", mreq0, 1);
    chk("s1_mem_a", ma0, 27'h104);
    chk("s1_mem_be", mbe0, 4'hF);
    chk("s1_mem_wr", mwr0, 0);
    chk("s1_mem_area", marea0, 0);
    step(); step();
    chk("s1_req_held", mreq0, 1);
    chk("s1_wait_held", wait0, 0);
    mdi0 = 32'hDEADBEEF; ack0 = 1'b1;
    step();
    ack0 = 1'b0;
    chk("s1_req_drop", mreq0, 0);
    chk("s1_wait_done", wait0, 1);
    chk("s1_di", di0, 32'hDEADBEEF);
    step();
    chk("s1_wait_end", wait0, 1);
    release_bus();
    step();

    // Byte write, area 2
    A = 27'h0000208; DO = 32'h00AB0000; RD_WR_N = 1'b0; WE_N = 4'b1101;
    cs_n = 4'b1011; BS_N = 1'b0;
    step();
    BS_N = 1'b1;
    chk("s2_mem_wr", mwr0, 1);
    chk("s2_mem_be", mbe0, 4'b0010);
    chk("s2_mem_area", marea0, 2);
    chk("s2_mem_do", mdo0, 32'h00AB0000);
    chk("s2_mem_a", ma0, 27'h208);
    mdi0 = 32'h12345678; ack0 = 1'b1;
    step();
    ack0 = 1'b0;
    chk("s2_wait_done", wait0, 1);
    chk("s2_di_kept", di0, 32'hDEADBEEF);
    step();
    release_bus();
    step();

    // Timeout on a read, then a late ACK
    start_rd(1, 27'h0000300);
    step();
    BS_N = 1'b1;
    repeat (8) step();
    chk("to_no_err_yet", berr0, 0);
    chk("to_wait_low", wait0, 0);
    chk("to_req_high", mreq0, 1);
    step();
    chk("to_bus_err", berr0, 1);
    chk("to_di_ones", di0, 32'hFFFFFFFF);
    chk("to_req_drop", mreq0, 0);
    chk("to_wait_high", wait0, 1);
    mdi0 = 32'h0BADF00D; ack0 = 1'b1;
    step();
    ack0 = 1'b0;
    chk("to_err_pulse", berr0, 0);
    chk("to_late_ack", di0, 32'hFFFFFFFF);
    release_bus();
    step();

    // ACK on the timeout CE_R is a normal completion
    start_rd(2, 27'h0000400);
    step();
    BS_N = 1'b1;
    repeat (8) step();
    mdi0 = 32'hA5A5A5A5; ack0 = 1'b1;
    step();
    ack0 = 1'b0;
    chk("tie_no_err", berr0, 0);
    chk("tie_di", di0, 32'hA5A5A5A5);
    chk("tie_wait", wait0, 1);
    step();
    release_bus();
    step();

    // Reset while in REQ
    start_rd(3, 27'h0000500);
    step();
    BS_N = 1'b1;
    step();
    RST = 1'b1;
    #1;
    chk("rr_wait", wait0, 1);
    chk("rr_req", mreq0, 0);
    chk("rr_di", di0, 0);
    #1;
    RST = 1'b0;
    release_bus();
    mdi0 = 32'h55555555; ack0 = 1'b1;
    step();
    ack0 = 1'b0;
    chk("rr_ack_ignored", di0, 0);
    chk("rr_req_idle", mreq0, 0);
    start_rd(0, 27'h0000600);
    step();
    BS_N = 1'b1;
    chk("rr_next_req", mreq0, 1);
    chk("rr_next_a", ma0, 27'h600);
    mdi0 = 32'hCAFEF00D; ack0 = 1'b1;
    step();
    ack0 = 1'b0;
    chk("rr_next_di", di0, 32'hCAFEF00D);
    step();
    release_bus();
    step();

    // CE_R at CLK/2: ACK between enables is latched, completion waits for CE_R
    start_rd(0, 27'h0000704);
    step();
    BS_N = 1'b1;
    ce0 = 1'b0; step();
    ce0 = 1'b1; step();
    ce0 = 1'b0; step();
    ce0 = 1'b1; step();
    ce0 = 1'b0; mdi0 = 32'h13579BDF; ack0 = 1'b1;
    step();
    ack0 = 1'b0;
    chk("ce2_req_drop", mreq0, 0);
    chk("ce2_wait_still", wait0, 0);
    chk("ce2_di", di0, 32'h13579BDF);
    ce0 = 1'b1; step();
    chk("ce2_done", wait0, 1);
    ce0 = 1'b0; step();
    chk("ce2_done_hold", wait0, 1);
    ce0 = 1'b1; step();
    release_bus();
    ce0 = 1'b0; step();
    ce0 = 1'b1; step();
    ce0 = 1'b0;

    // Second instance: disabled area 0, then MIN_WAIT=4 with immediate ACK
    ce1 = 1'b1;
    start_rd(0, 27'h0000800);
    chk("dis_wait", wait1, 1);
    step();
    chk("dis_no_req", mreq1, 0);
    chk("dis_wait_after", wait1, 1);
    release_bus();
    step();

    start_rd(1, 27'h0000900);
    step();
    BS_N = 1'b1;
    chk("mw_req", mreq1, 1);
    mdi1 = 32'h2468ACE0; ack1 = 1'b1;
    step();
    ack1 = 1'b0;
    chk("mw_req_drop", mreq1, 0);
    chk("mw_hold_wait", wait1, 0);
    chk("mw_di", di1, 32'h2468ACE0);
    repeat (3) step();
    chk("mw_wait_4th", wait1, 0);
    step();
    chk("mw_done", wait1, 1);
    step();
    release_bus();
    step();
    ce1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
